pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
Multi-channel, width-parametrised PWM generator for servo and motor outputs.
- All channels share one period counter.
- Each channel has its own duty compare.
- Period, duty and alignment mode are double-buffered: new values take effect only at a period boundary, so no glitched or runt pulses are produced.
- Edge-aligned and center-aligned counting are supported. It sits between the control/register logic and the output pins.

Parameters:
WIDTH, 32, bit width of counter, period and each duty value
CHANNELS, 4, number of independent PWM outputs (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = run; 0 = counter held at 0, outputs 0
period  input  WIDTH  requested period value P
duty  input  CHANNELS*WIDTH  requested duty values; channel i uses bits [i*WIDTH +: WIDTH]
center_mode  input  1  requested mode: 0 = edge-aligned, 1 = center-aligned
load  input  1  one-cycle strobe; samples period/duty/center_mode into the pending buffer
pwm_out  output  CHANNELS  registered PWM outputs
cycle_start  output  1  one-cycle pulse at each period boundary
update_done  output  1  one-cycle pulse when pending values become active
busy  output  1  1 while a load is pending (not yet applied)

Behaviour:
- Reset (async, rst=1):
  - cnt=0, direction=up, pending flag=0.
  - Active period/duty/mode = 0.
  - pwm_out=0, cycle_start=0, update_done=0, busy=0.
- Storage: active registers (ap, ad[i], am) and pending registers.
  - load=1 copies inputs into pending and sets busy.
  - A load while busy overwrites pending; only the last load is applied.
- Boundary: the cycle in which cnt advances to 0 (or is held at 0 with ap<=1).
  - If busy at the boundary: pending→active, busy→0, update_done=1 on the next cycle.
  - load coincident with a boundary bypasses pending: the new values become active at that boundary directly, with update_done pulsed.
- enable=0:
  - cnt and direction are reset to 0/up; pwm_out=0; cycle_start=0.
  - A pending or new load is applied immediately (next cycle), pulsing update_done.
- Edge mode (am=0):
  - cnt runs 0..ap-1, then wraps to 0.
  - Output period = ap cycles.
- Center mode (am=1):
  - cnt counts up 0..ap-1, then down ap-2..1, then to 0.
  - Output period = 2*ap-2 cycles for ap>=2.
  - ap<=1 holds cnt at 0.
- Compare: pwm_out[i] <= (cnt < ad[i]), registered, so one cycle of latency from cnt.
  - Edge mode: high ad[i] cycles per period.
  - Center mode: high 2*ad[i]-1 cycles for 1<=ad[i]<=ap-1.
- Boundary conditions:
  - ad=0 → constant 0.
  - ad>=ap (ap>0) → constant 1.
  - ap=0 → cnt held 0, all outputs 0, a boundary occurs every cycle.
  - All comparisons are unsigned WIDTH-bit. ap-1 is computed only when ap>0; there is no wrap-around.
- cycle_start: registered, asserted for one cycle whenever cnt==0 while enable=1 and ap>0.
- A mode change via load takes effect only at a boundary; the counter restarts from 0/up.
- Reset asserted mid-period aborts immediately to the reset state and discards any pending load.

Optional Feature:
Macro PWM_POLARITY_EN.
- Defined: adds input port polarity [CHANNELS]. It is double-buffered with duty (captured on load, applied at the boundary). Each pwm_out[i] = compare result XOR active polarity[i]. Outputs remain 0 during reset and while enable=0.
- Undefined: no polarity port; outputs are active-high only.

Test Plan:
- Edge, load P=10, duty ch0=3, ch1=0, ch2=10, ch3=7, enable=1 → ch0 high 3 of every 10 cycles; ch1 constant 0; ch2 constant 1; ch3 high 7 of 10; cycle_start every 10 cycles.
- Center, P=5, duty ch0=2 → period 8 cycles; ch0 high 3 consecutive cycles, centered around cnt=0; cycle_start every 8 cycles.
- Running edge P=10 D=3: load D=6 at cnt=4 → busy=1; current period keeps 3 high cycles; update_done pulses after the boundary; next period has 6 high cycles.
- Two loads (D=5, then D=8) within one period → only D=8 is applied; one update_done pulse.
- load at the exact boundary cycle with P=4 D=1 → new values used for the period starting at that boundary (bypass); busy never asserted.
- Assert rst at cnt=6 with a pending load → all outputs 0 within the same cycle. After release with enable=1 and ap=0, outputs stay 0 until a new load.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with one shared period counter,
// per-channel duty compare and double-buffered period/duty/mode settings.
// Edge-aligned and center-aligned counting.
// Build option: define PWM_POLARITY_EN to add a per-channel output polarity
// input, buffered together with duty and applied at the period boundary.
module pwm_multi #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      center_mode,
    input  logic                      load,
`ifdef PWM_POLARITY_EN
    input  logic [CHANNELS-1:0]       polarity,
`endif
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      cycle_start,
    output logic                      update_done,
    output logic                      busy
);

    localparam int unsigned DW = CHANNELS * WIDTH;

    // Counter state
    logic [WIDTH-1:0]    cnt;
    logic                dir;        // 0 = counting up, 1 = counting down

    // Active settings
    logic [WIDTH-1:0]    ap;
    logic [DW-1:0]       ad;
    logic                am;
    logic [CHANNELS-1:0] apol;

    // Pending settings
    logic [WIDTH-1:0]    pp;
    logic [DW-1:0]       pd;
    logic                pm;
    logic [CHANNELS-1:0] ppol;

    // Combinational helpers
    logic [WIDTH-1:0]    ap_m1;
    logic [WIDTH-1:0]    cnt_adv;
    logic                dir_adv;
    logic                boundary;
    logic                apply;
    logic [CHANNELS-1:0] cmp;
    logic [CHANNELS-1:0] pol_in;

`ifdef PWM_POLARITY_EN
    assign pol_in = polarity;
`else
    assign pol_in = '0;
`endif

    // Next counter value and direction for a free-running period
    always_comb begin
        ap_m1   = '0;
        cnt_adv = '0;
        dir_adv = 1'b0;
        if (ap != '0) begin
            ap_m1 = ap - WIDTH'(1);
            if (!am) begin
                if (cnt < ap_m1) begin
                    cnt_adv = cnt + WIDTH'(1);
                end
            end else if (ap > WIDTH'(1)) begin
                if (!dir) begin
                    if (cnt >= ap_m1) begin
                        cnt_adv = cnt - WIDTH'(1);
                        dir_adv = 1'b1;
                    end else begin
                        cnt_adv = cnt + WIDTH'(1);
                    end
                end else if (cnt > WIDTH'(1)) begin
                    cnt_adv = cnt - WIDTH'(1);
                    dir_adv = 1'b1;
                end
            end
        end
    end

    // Period boundary: counter about to return to 0; settings may be swapped
    assign boundary = enable && (cnt_adv == '0);
    assign apply    = !enable || boundary;

    // Per-channel duty compare against the current count
    always_comb begin
        cmp = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cmp[i] = (cnt < ad[i*WIDTH +: WIDTH]);
        end
    end

    // Counter and direction; restart from 0/up at every boundary or when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            dir <= 1'b0;
        end else if (apply) begin
            cnt <= '0;
            dir <= 1'b0;
        end else begin
            cnt <= cnt_adv;
            dir <= dir_adv;
        end
    end

    // Active/pending settings, busy flag and update pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ap          <= '0;
            ad          <= '0;
            am          <= 1'b0;
            apol        <= '0;
            pp          <= '0;
            pd          <= '0;
            pm          <= 1'b0;
            ppol        <= '0;
            busy        <= 1'b0;
            update_done <= 1'b0;
        end else begin
            update_done <= 1'b0;
            if (apply) begin
                if (load) begin
                    ap          <= period;
                    ad          <= duty;
                    am          <= center_mode;
                    apol        <= pol_in;
                    busy        <= 1'b0;
                    update_done <= 1'b1;
                end else if (busy) begin
                    ap          <= pp;
                    ad          <= pd;
                    am          <= pm;
                    apol        <= ppol;
                    busy        <= 1'b0;
                    update_done <= 1'b1;
                end
            end else if (load) begin
                pp   <= period;
                pd   <= duty;
                pm   <= center_mode;
                ppol <= pol_in;
                busy <= 1'b1;
            end
        end
    end

    // Registered outputs; forced low while idle or with a zero period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out     <= '0;
            cycle_start <= 1'b0;
        end else begin
            cycle_start <= enable && (ap != '0) && (cnt == '0);
            pwm_out     <= (enable && (ap != '0)) ? (cmp ^ apol) : '0;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed testbench for pwm_multi (WIDTH=32, CHANNELS=4).
module tb_pwm_multi;

    localparam int unsigned W = 32;
    localparam int unsigned C = 4;

    logic           clk;
    logic           rst;
    logic           enable;
    logic [W-1:0]   period;
    logic [C*W-1:0] duty;
    logic           center_mode;
    logic           load;
`ifdef PWM_POLARITY_EN
    logic [C-1:0]   polarity;
`endif
    logic [C-1:0]   pwm_out;
    logic           cycle_start;
    logic           update_done;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_multi #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .period      (period),
        .duty        (duty),
        .center_mode (center_mode),
        .load        (load),
`ifdef PWM_POLARITY_EN
        .polarity    (polarity),
`endif
        .pwm_out     (pwm_out),
        .cycle_start (cycle_start),
        .update_done (update_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; observe 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles, counting high observations per channel and pulses
    task automatic run(input int n, output int h0, output int h1, output int h2,
                       output int h3, output int cs, output int ud);
        h0 = 0; h1 = 0; h2 = 0; h3 = 0; cs = 0; ud = 0;
        repeat (n) begin
            tick();
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            h2 += int'(pwm_out[2]);
            h3 += int'(pwm_out[3]);
            cs += int'(cycle_start);
            ud += int'(update_done);
        end
    endtask

    task automatic wait_cs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cycle_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ud(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (update_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int h0, h1, h2, h3, cs, ud, hi, run_len, max_run;
        bit ok;

        rst = 1'b0; enable = 1'b0; period = '0; duty = '0;
        center_mode = 1'b0; load = 1'b0;
`ifdef PWM_POLARITY_EN
        polarity = '0;
`endif
        #2 rst = 1'b1;
        tick();
        tick();
        check("rst_pwm", 64'(pwm_out), 64'd0);
        check("rst_cs", 64'(cycle_start), 64'd0);
        check("rst_ud", 64'(update_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Edge mode P=10, duty {7,10,0,3}; ap=0 so the load applies at once
        rst = 1'b0; enable = 1'b1; period = 32'd10;
        duty = {32'd7, 32'd10, 32'd0, 32'd3}; load = 1'b1;
        tick();
        load = 1'b0;
        check("edge_load_ud", 64'(update_done), 64'd1);
        check("edge_load_busy", 64'(busy), 64'd0);
        run(5, h0, h1, h2, h3, cs, ud);
        run(10, h0, h1, h2, h3, cs, ud);
        check("edge_ch0_hi", 64'(h0), 64'd3);
        check("edge_ch1_hi", 64'(h1), 64'd0);
        check("edge_ch2_hi", 64'(h2), 64'd10);
        check("edge_ch3_hi", 64'(h3), 64'd7);
        check("edge_cs", 64'(cs), 64'd1);

        // Load D=6 at cnt=4: current period keeps 3 highs, next has 6
        wait_cs(ok);
        check("upd_sync", 64'(ok), 64'd1);
        hi = int'(pwm_out[0]);
        repeat (3) begin
            tick();
            hi += int'(pwm_out[0]);
        end
        duty = {32'd7, 32'd10, 32'd0, 32'd6}; load = 1'b1;
        tick();
        hi += int'(pwm_out[0]);
        load = 1'b0;
        check("upd_busy", 64'(busy), 64'd1);
        check("upd_ud_early", 64'(update_done), 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            hi += int'(pwm_out[0]);
            if (update_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("upd_ud_seen", 64'(ok), 64'd1);
        check("upd_old_hi", 64'(hi), 64'd3);
        check("upd_busy_clr", 64'(busy), 64'd0);
        tick();
        check("upd_ud_pulse", 64'(update_done), 64'd0);
        run(10, h0, h1, h2, h3, cs, ud);
        check("upd_new_hi", 64'(h0), 64'd6);

        // Two loads in one period: only the last (D=8) is applied, once
        wait_cs(ok);
        check("dbl_sync", 64'(ok), 64'd1);
        tick();
        tick();
        duty = {32'd7, 32'd10, 32'd0, 32'd5}; load = 1'b1;
        tick();
        load = 1'b0;
        check("dbl_busy", 64'(busy), 64'd1);
        tick();
        duty = {32'd7, 32'd10, 32'd0, 32'd8}; load = 1'b1;
        tick();
        load = 1'b0;
        run(25, h0, h1, h2, h3, cs, ud);
        check("dbl_ud_count", 64'(ud), 64'd1);
        check("dbl_busy_clr", 64'(busy), 64'd0);
        run(10, h0, h1, h2, h3, cs, ud);
        check("dbl_hi", 64'(h0), 64'd8);

        // Load on the boundary cycle (cnt=9): bypass, P=4 D=1
        wait_cs(ok);
        check("byp_sync", 64'(ok), 64'd1);
        repeat (8) tick();
        period = 32'd4; duty = {32'd7, 32'd10, 32'd0, 32'd1}; load = 1'b1;
        tick();
        load = 1'b0;
        check("byp_busy", 64'(busy), 64'd0);
        check("byp_ud", 64'(update_done), 64'd1);
        tick();
        run(8, h0, h1, h2, h3, cs, ud);
        check("byp_ch0_hi", 64'(h0), 64'd2);
        check("byp_ch1_hi", 64'(h1), 64'd0);
        check("byp_ch2_hi", 64'(h2), 64'd8);
        check("byp_ch3_hi", 64'(h3), 64'd8);
        check("byp_cs", 64'(cs), 64'd2);
        check("byp_ud_none", 64'(ud), 64'd0);

        // Center mode P=5 D=2: period 8, 3 consecutive highs
        wait_cs(ok);
        check("ctr_sync", 64'(ok), 64'd1);
        period = 32'd5; duty = {32'd7, 32'd10, 32'd0, 32'd2};
        center_mode = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        check("ctr_busy", 64'(busy), 64'd1);
        wait_ud(ok);
        check("ctr_ud", 64'(ok), 64'd1);
        tick();
        run(8, h0, h1, h2, h3, cs, ud);
        check("ctr_ch0_hi", 64'(h0), 64'd3);
        check("ctr_ch2_hi", 64'(h2), 64'd8);
        check("ctr_cs", 64'(cs), 64'd1);
        run_len = 0; max_run = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            run_len = pwm_out[0] ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
        end
        check("ctr_run", 64'(max_run), 64'd3);

        // Reset mid-period with a pending load
        period = 32'd10; duty = {32'd7, 32'd10, 32'd0, 32'd3};
        center_mode = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        if (!update_done) begin
            wait_ud(ok);
            check("rstm_ud", 64'(ok), 64'd1);
        end
        wait_cs(ok);
        check("rstm_sync", 64'(ok), 64'd1);
        tick();
        tick();
        duty = {32'd7, 32'd10, 32'd0, 32'd6}; load = 1'b1;
        tick();
        load = 1'b0;
        check("rstm_busy", 64'(busy), 64'd1);
        tick();
        tick();
        check("rstm_pre_pwm", 64'(pwm_out), 64'(4'b1100));
        rst = 1'b1;
        #1;
        check("rstm_pwm", 64'(pwm_out), 64'd0);
        check("rstm_cs", 64'(cycle_start), 64'd0);
        check("rstm_ud0", 64'(update_done), 64'd0);
        check("rstm_busy0", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        run(12, h0, h1, h2, h3, cs, ud);
        check("rstm_after_pwm", 64'(h0 + h1 + h2 + h3), 64'd0);
        check("rstm_after_cs", 64'(cs), 64'd0);
        check("rstm_after_ud", 64'(ud), 64'd0);

        // enable=0: load applies next cycle, outputs stay low
        enable = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        check("dis_ud", 64'(update_done), 64'd1);
        check("dis_pwm", 64'(pwm_out), 64'd0);
        run(6, h0, h1, h2, h3, cs, ud);
        check("dis_run_pwm", 64'(h0 + h1 + h2 + h3), 64'd0);
        check("dis_run_cs", 64'(cs), 64'd0);
        enable = 1'b1;
        run(10, h0, h1, h2, h3, cs, ud);
        check("ena_ch0_hi", 64'(h0), 64'd6);
        check("ena_ch2_hi", 64'(h2), 64'd10);
        check("ena_cs", 64'(cs), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
